// File: rtl/reg_writeback.sv
// Write-back buffer for the 4-entry register group.
// Queues execute results in order and drains one write per cycle.
module reg_writeback #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [1:0]        wb_rd,
  input  logic [DWIDTH-1:0] wb_data,
  input  logic              wr_hold,
  output logic [3:0]        reg_en,
  output logic [DWIDTH-1:0] d_out,
  output logic [3:0]        pend,
  output logic              idle
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [1:0]        rd_q   [DEPTH];
  logic [DWIDTH-1:0] data_q [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  assign wb_ready = (count < CW'(DEPTH));
  assign push     = wb_valid && wb_ready;
  assign pop      = (count != '0) && !wr_hold;

  // Storage carries no reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wr_ptr]   <= wb_rd;
      data_q[wr_ptr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_en <= '0;
      d_out  <= '0;
    end else if (pop) begin
      reg_en <= onehot(rd_q[rd_ptr]);
      d_out  <= data_q[rd_ptr];
    end else begin
      reg_en <= '0;
    end
  end

  // Walk valid entries from the head; the in-flight write also counts.
  always_comb begin
    pend = reg_en;
    for (int j = 0; j < DEPTH; j++) begin
      if (CW'(j) < count)
        pend = pend | onehot(rd_q[rd_ptr + PW'(j)]);
    end
  end

  assign idle = (count == '0) && (reg_en == 4'b0000);

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-side companion to the 4-entry register group read stage.
- Accepts results (destination index plus data) from the execute stage over a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains one entry per cycle onto the register group write port as a one-hot write enable plus shared data bus.
- Publishes a per-register pending-write mask so issue logic can stall reads of registers with writes in flight.

Parameters:
- DWIDTH, 16, data width; must match the register group.
- DEPTH, 2, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_valid  in  1  write request valid.
- wb_ready  out  1  FIFO can accept this cycle.
- wb_rd  in  2  destination register index 0..3.
- wb_data  in  DWIDTH  value to write.
- wr_hold  in  1  suppress draining (write port blocked).
- reg_en  out  4  one-hot write enable to the register group; all-zero when idle.
- d_out  out  DWIDTH  write data to the register group.
- pend  out  4  bit i set while any write to register i is queued or being driven.
- idle  out  1  FIFO empty and reg_en == 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - reg_en = 0, d_out = 0, pend = 0, idle = 1.
  - FIFO pointers and count = 0.
  - wb_ready = 1 (combinational from count).
  - wb_valid is ignored while rst_n = 0.
- Reset mid-operation: all queued entries and the in-flight write are discarded immediately. No partial write is issued.
- Handshake:
  - Push occurs at an edge where wb_valid && wb_ready.
  - wb_ready = (count < DEPTH), combinational from registered count only. There is no path from wb_valid to wb_ready.
  - When full, no push is accepted even if a pop happens the same edge.
  - The sender must hold wb_rd and wb_data stable while wb_valid && !wb_ready.
- Drain (output stage registered):
  - At each edge with count > 0 and wr_hold = 0: pop the head, reg_en <= one-hot(head.rd), d_out <= head.data.
  - Otherwise reg_en <= 0 and d_out holds its last value.
  - reg_en is high for exactly one cycle per entry.
  - The register group captures d_out at the edge ending that cycle.
- Latency:
  - Entry pushed at edge N is popped at edge N+1 at the earliest. reg_en is high during cycle N+1..N+2.
  - The register holds the new value after edge N+2.
  - Back-to-back pushes drain at 1 entry/cycle with no bubbles.
- Simultaneous push and pop (not full): count unchanged, both take effect. The pushed entry never bypasses older entries.
- Ordering: strict FIFO order. Multiple entries to the same register write in order, so the last pushed value wins.
- wr_hold:
  - Sampled every edge. While high: no pop, reg_en = 0 after the next edge, FIFO contents kept.
  - Pushes continue up to full.
  - When wr_hold deasserts, draining resumes from the same head.
- Pointers: read/write pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- pend: combinational. pend[i] = OR over valid FIFO entries (rd == i) OR reg_en[i].
  - Set in the cycle after the push edge.
  - Clears in the cycle after the edge that ends the last reg_en[i] pulse.
- idle = (count == 0) && (reg_en == 0).

Test Plan:
- Reset then single write: push rd=2, data=0x1234 at edge 1 -> reg_en=4'b0100, d_out=0x1234 during cycle 2; pend=4'b0100 during cycles 1-2; idle=1 from cycle 3.
- Burst of 4 pushes on consecutive cycles (rd=0,1,2,3; data=0xA0..0xA3), DEPTH=2 -> wb_ready never drops; reg_en 0001,0010,0100,1000 on consecutive cycles with matching data.
- Backpressure: wr_hold=1, push rd=1 0x0011 then rd=3 0x0033 -> wb_ready=0 after second push; a third wb_valid is held unaccepted; release wr_hold -> writes 0x0011, 0x0033, then third entry, in order; no loss or duplication.
- Same-register ordering: push rd=0 0x1111 then rd=0 0x2222 -> two reg_en=0001 pulses, 0x1111 then 0x2222; pend[0] high continuously until after the second pulse.
- Reset mid-burst: two entries queued, reg_en active, assert rst_n=0 asynchronously between edges -> reg_en=0, pend=0, wb_ready=1, idle=1 immediately; after release, no stale writes are issued.
- Random valid/hold (10k cycles) against a reference queue model -> every accepted entry written exactly once, in order; reg_en always one-hot or zero.
